naneye_tx_encoder: RTL and testbench

Sensor-side serial transmitter: the encoder counterpart of the RX decoder / deserializer chain. Takes a pixel stream from a pixel source (pattern generator or frame RAM), frames it into rows and frames, and Manchester-encodes it onto a single serial line in the format the receive path decodes. Used as the sensor model in loopback benches and as the on-board test-pattern source feeding `RX_DATA`.

---
 rtl/naneye_tx_encoder.sv | 180 ++++++++++++++++++
 tb/tb_naneye_tx_encoder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/naneye_tx_encoder.sv
// NanEye-style serial transmitter: frames a pixel stream into rows/frames and
// Manchester-encodes it onto one line (frame sync, start/data/stop words, line gaps).
module naneye_tx_encoder #(
  parameter int D_WIDTH          = 10,
  parameter int C_ROWS           = 320,
  parameter int C_COLUMNS        = 320,
  parameter int HALF_BIT_CYCLES  = 4,
  parameter int FS_HIGH_HALFBITS = 16,
  parameter int FS_LOW_HALFBITS  = 4,
  parameter int LINE_GAP_BITS    = 8
) (
  input  logic               CLOCK,
  input  logic               RESET,
  input  logic               ENABLE,
  output logic               PIX_REQ,
  input  logic [D_WIDTH-1:0] PIX_DATA,
  output logic               TX_DATA,
  output logic               TX_OE,
  output logic               LINE_START,
  output logic               FRAME_DONE,
  output logic [9:0]         ROW_CNT
);

  localparam int WORD_HB = 2 * (D_WIDTH + 2);
  localparam int GAP_HB  = 2 * LINE_GAP_BITS;
  localparam int HB_MAX1 = (FS_HIGH_HALFBITS > FS_LOW_HALFBITS) ? FS_HIGH_HALFBITS : FS_LOW_HALFBITS;
  localparam int HB_MAX2 = (WORD_HB > GAP_HB) ? WORD_HB : GAP_HB;
  localparam int HB_MAX  = (HB_MAX1 > HB_MAX2) ? HB_MAX1 : HB_MAX2;
  localparam int HB_W    = $clog2(HB_MAX);
  localparam int CYC_W   = (HALF_BIT_CYCLES > 1) ? $clog2(HALF_BIT_CYCLES) : 1;
  localparam int COL_W   = (C_COLUMNS > 1) ? $clog2(C_COLUMNS) : 1;

  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(HALF_BIT_CYCLES - 1);
  localparam logic [CYC_W-1:0] CYC_PRE  = CYC_W'((HALF_BIT_CYCLES >= 2) ? HALF_BIT_CYCLES - 2 : 0);
  localparam logic [CYC_W-1:0] CYC_ONE  = CYC_W'(1);
  localparam logic [HB_W-1:0]  FSH_LAST = HB_W'(FS_HIGH_HALFBITS - 1);
  localparam logic [HB_W-1:0]  FSL_LAST = HB_W'(FS_LOW_HALFBITS - 1);
  localparam logic [HB_W-1:0]  WRD_LAST = HB_W'(WORD_HB - 1);
  localparam logic [HB_W-1:0]  GAP_LAST = HB_W'(GAP_HB - 1);
  localparam logic [HB_W-1:0]  STOP_BIT = HB_W'(D_WIDTH + 1);
  localparam logic [HB_W-1:0]  HB_ONE   = HB_W'(1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(C_COLUMNS - 1);
  localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
  localparam logic [9:0]       ROW_LAST = 10'(C_ROWS - 1);
  localparam logic [9:0]       ROW_ONE  = 10'd1;
  localparam bit               ONE_CYC  = (HALF_BIT_CYCLES == 1);

  typedef enum logic [2:0] {IDLE, FSYNC_H, FSYNC_L, WORD, LGAP} state_t;

  state_t             state, nxt_state;
  logic [CYC_W-1:0]   cyc, nxt_cyc;
  logic [HB_W-1:0]    hb, nxt_hb, nxt_last, nxt_bit;
  logic [COL_W-1:0]   col, nxt_col;
  logic [9:0]         row, nxt_row;
  logic [D_WIDTH-1:0] hold, shift;
  logic               req_d, nxt_line, nxt_pre_end, nxt_word_follows;

  function automatic logic [HB_W-1:0] last_hb(input state_t s);
    case (s)
      FSYNC_H: return FSH_LAST;
      FSYNC_L: return FSL_LAST;
      WORD:    return WRD_LAST;
      LGAP:    return GAP_LAST;
      default: return '0;
    endcase
  endfunction

  // Position (segment, half-bit, cycle) of the line on the coming cycle.
  always_comb begin
    nxt_state = state;
    nxt_cyc   = cyc;
    nxt_hb    = hb;
    nxt_col   = col;
    nxt_row   = row;
    if (state == IDLE) begin
      nxt_cyc = '0;
      nxt_hb  = '0;
      nxt_col = '0;
      nxt_row = '0;
      if (ENABLE) nxt_state = FSYNC_H;
    end else if (cyc != CYC_LAST) begin
      nxt_cyc = cyc + CYC_ONE;
    end else begin
      nxt_cyc = '0;
      if (hb != last_hb(state)) begin
        nxt_hb = hb + HB_ONE;
      end else begin
        nxt_hb = '0;
        case (state)
          FSYNC_H: nxt_state = FSYNC_L;
          FSYNC_L: begin
            nxt_state = WORD;
            nxt_col   = '0;
            nxt_row   = '0;
          end
          WORD: begin
            if (col != COL_LAST) nxt_col = col + COL_ONE;
            else                 nxt_state = LGAP;
          end
          LGAP: begin
            nxt_col = '0;
            if (row != ROW_LAST) begin
              nxt_state = WORD;
              nxt_row   = row + ROW_ONE;
            end else begin
              nxt_row   = '0;
              nxt_state = ENABLE ? FSYNC_H : IDLE;
            end
          end
          default: nxt_state = IDLE;
        endcase
      end
    end
  end

  // Line level and pixel-request timing for that coming position.
  always_comb begin
    nxt_last = last_hb(nxt_state);
    nxt_bit  = nxt_hb >> 1;
    nxt_line = 1'b0;
    case (nxt_state)
      FSYNC_H: nxt_line = 1'b1;
      LGAP:    nxt_line = nxt_hb[0];
      WORD: begin
        if (nxt_bit == '0)           nxt_line = ~nxt_hb[0];
        else if (nxt_bit == STOP_BIT) nxt_line = nxt_hb[0];
        else                          nxt_line = nxt_hb[0] ^ shift[D_WIDTH-1];
      end
      default: nxt_line = 1'b0;
    endcase
    // Two cycles before a segment ends: the request lands exactly two cycles ahead of the start bit.
    if (ONE_CYC) nxt_pre_end = (nxt_hb == nxt_last - HB_ONE);
    else         nxt_pre_end = (nxt_cyc == CYC_PRE) && (nxt_hb == nxt_last);
    nxt_word_follows = (nxt_state == FSYNC_L) ||
                       ((nxt_state == WORD) && (nxt_col != COL_LAST)) ||
                       ((nxt_state == LGAP) && (nxt_row != ROW_LAST));
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state      <= IDLE;
      cyc        <= '0;
      hb         <= '0;
      col        <= '0;
      row        <= '0;
      hold       <= '0;
      shift      <= '0;
      req_d      <= 1'b0;
      PIX_REQ    <= 1'b0;
      TX_DATA    <= 1'b0;
      TX_OE      <= 1'b0;
      LINE_START <= 1'b0;
      FRAME_DONE <= 1'b0;
      ROW_CNT    <= '0;
    end else begin
      state      <= nxt_state;
      cyc        <= nxt_cyc;
      hb         <= nxt_hb;
      col        <= nxt_col;
      row        <= nxt_row;
      TX_OE      <= (nxt_state != IDLE);
      ROW_CNT    <= nxt_row;
      PIX_REQ    <= (nxt_state != IDLE) && nxt_pre_end && nxt_word_follows;
      LINE_START <= (nxt_state == WORD) && (nxt_col == '0) && (nxt_hb == '0) && (nxt_cyc == '0);
      FRAME_DONE <= (nxt_state == LGAP) && (nxt_row == ROW_LAST) &&
                    (nxt_hb == GAP_LAST) && (nxt_cyc == CYC_LAST);
      req_d      <= PIX_REQ;
      if (req_d) hold <= PIX_DATA;
      // Data is loaded during the start bit's second half and shifted mid-bit, so the MSB is stable for each bit's first half.
      if (nxt_cyc == '0) begin
        TX_DATA <= nxt_line;
        if ((nxt_state == WORD) && nxt_hb[0]) begin
          if (nxt_bit == '0)            shift <= hold;
          else if (nxt_bit != STOP_BIT) shift <= shift << 1;
        end
      end
    end
  end

endmodule

// File: tb/tb_naneye_tx_encoder.sv
// Randomized scoreboard bench for naneye_tx_encoder: a frame-level reference model
// queues the expected per-cycle line behaviour; a monitor pops and compares.
module tb_naneye_tx_encoder;

  localparam int D_WIDTH   = 10;
  localparam int C_ROWS    = 2;
  localparam int C_COLUMNS = 3;
  localparam int HBC       = 2;
  localparam int FSH       = 4;
  localparam int FSL       = 2;
  localparam int LGB       = 1;
  localparam int FRAME_LEN = HBC * (FSH + FSL + C_ROWS * (C_COLUMNS * 2 * (D_WIDTH + 2) + 2 * LGB));

  typedef struct packed {
    logic       tx_data;
    logic       tx_oe;
    logic       pix_req;
    logic       line_start;
    logic       frame_done;
    logic [9:0] row_cnt;
  } obs_t;

  logic               CLOCK = 1'b0;
  logic               RESET;
  logic               ENABLE;
  logic [D_WIDTH-1:0] PIX_DATA;
  logic               PIX_REQ, TX_DATA, TX_OE, LINE_START, FRAME_DONE;
  logic [9:0]         ROW_CNT;

  obs_t               exp_q[$];
  logic [D_WIDTH-1:0] pix_q[$];
  int                 errors = 0;
  int                 checks = 0;
  int                 cyc_no = 0;
  bit                 mon_en = 1'b0;

  naneye_tx_encoder #(
    .D_WIDTH(D_WIDTH), .C_ROWS(C_ROWS), .C_COLUMNS(C_COLUMNS),
    .HALF_BIT_CYCLES(HBC), .FS_HIGH_HALFBITS(FSH), .FS_LOW_HALFBITS(FSL),
    .LINE_GAP_BITS(LGB)
  ) dut (
    .CLOCK(CLOCK), .RESET(RESET), .ENABLE(ENABLE), .PIX_REQ(PIX_REQ),
    .PIX_DATA(PIX_DATA), .TX_DATA(TX_DATA), .TX_OE(TX_OE),
    .LINE_START(LINE_START), .FRAME_DONE(FRAME_DONE), .ROW_CNT(ROW_CNT)
  );

  always #5 CLOCK = ~CLOCK;

  function automatic obs_t sampleDut();
    return {TX_DATA, TX_OE, PIX_REQ, LINE_START, FRAME_DONE, ROW_CNT};
  endfunction

  task automatic checkOutput(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s cycle=%0d got tx=%b oe=%b req=%b ls=%b fd=%b row=%0d expected tx=%b oe=%b req=%b ls=%b fd=%b row=%0d",
               name, cyc_no, act.tx_data, act.tx_oe, act.pix_req, act.line_start, act.frame_done, act.row_cnt,
               exp.tx_data, exp.tx_oe, exp.pix_req, exp.line_start, exp.frame_done, exp.row_cnt);
    end
  endtask

  task automatic reportTimeout(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s timeout at cycle=%0d queued=%0d required=0", name, cyc_no, exp_q.size());
  endtask

  // Reference frame: built from the line format itself (sync, words, gaps), one entry per cycle.
  task automatic addFrame(input int mode);
    obs_t               f[$];
    obs_t               e;
    int                 starts[$];
    int                 ramp;
    logic [D_WIDTH-1:0] px;
    logic [D_WIDTH+1:0] word;
    bit                 first;
    ramp = 0;
    e = '0;
    e.tx_oe = 1'b1;
    repeat (FSH * HBC) begin e.tx_data = 1'b1; f.push_back(e); end
    repeat (FSL * HBC) begin e.tx_data = 1'b0; f.push_back(e); end
    for (int r = 0; r < C_ROWS; r++) begin
      e.row_cnt = 10'(r);
      for (int c = 0; c < C_COLUMNS; c++) begin
        if (mode == 0)      px = 10'h2A5;
        else if (mode == 1) px = D_WIDTH'(ramp);
        else                px = D_WIDTH'($urandom);
        ramp++;
        pix_q.push_back(px);
        word = {1'b1, px, 1'b0};
        starts.push_back(f.size());
        first = (c == 0);
        for (int b = D_WIDTH + 1; b >= 0; b--) begin
          for (int h = 0; h < 2; h++) begin
            repeat (HBC) begin
              e.tx_data    = word[b] ^ h[0];
              e.line_start = first;
              first        = 1'b0;
              f.push_back(e);
            end
          end
        end
      end
      e.line_start = 1'b0;
      repeat (LGB) begin
        repeat (HBC) begin e.tx_data = 1'b0; f.push_back(e); end
        repeat (HBC) begin e.tx_data = 1'b1; f.push_back(e); end
      end
    end
    f[f.size()-1].frame_done = 1'b1;
    foreach (starts[i]) f[starts[i]-2].pix_req = 1'b1;
    foreach (f[i]) exp_q.push_back(f[i]);
  endtask

  // Pixel source: serves the next queued pixel in answer to each request.
  always @(negedge CLOCK) begin
    if (mon_en && PIX_REQ === 1'b1) begin
      checks++;
      if (pix_q.size() > 0) PIX_DATA = pix_q.pop_front();
      else begin
        errors++;
        $display("[TB] FAIL pix_underflow cycle=%0d got request with 0 pixels queued, required >=1", cyc_no);
      end
    end
  end

  // Monitor: every cycle's outputs against the queued expectation (idle outputs when the queue is empty).
  always @(negedge CLOCK) begin
    if (mon_en) begin
      obs_t exp;
      cyc_no++;
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      checkOutput("stream", sampleDut(), exp);
    end
  end

  task automatic applyStimulus(input int n_frames, input int mode);
    int guard;
    @(posedge CLOCK); #1;
    ENABLE = 1'b1;
    exp_q.push_back('0);
    for (int i = 0; i < n_frames; i++) addFrame(i == 0 ? mode : 2);
    @(posedge CLOCK); #1;
    guard = 0;
    while (exp_q.size() > FRAME_LEN && guard < n_frames * FRAME_LEN + 10) begin
      @(posedge CLOCK); #1;
      guard++;
    end
    if (exp_q.size() > FRAME_LEN) reportTimeout("last_frame_wait");
    ENABLE = 1'b0;
    guard = 0;
    while (exp_q.size() > 0 && guard < FRAME_LEN + 10) begin
      @(posedge CLOCK); #1;
      guard++;
    end
    if (exp_q.size() > 0) reportTimeout("frame_drain");
    repeat (6) @(posedge CLOCK);
    #1;
  endtask

  task automatic applyMidFrameReset();
    int guard;
    @(posedge CLOCK); #1;
    ENABLE = 1'b1;
    exp_q.push_back('0);
    addFrame(2);
    @(posedge CLOCK); #1;
    ENABLE = 1'b0;
    guard = 0;
    // Frame cycle index 265 lies inside row 1, word 2.
    while (exp_q.size() != FRAME_LEN - 265 && guard < FRAME_LEN + 10) begin
      @(posedge CLOCK); #1;
      guard++;
    end
    if (exp_q.size() != FRAME_LEN - 265) reportTimeout("reset_point");
    RESET = 1'b1;
    @(negedge CLOCK); #1;
    exp_q.delete();
    pix_q.delete();
    @(posedge CLOCK); #1;
    checkOutput("mid_frame_reset", sampleDut(), '0);
    RESET = 1'b0;
    repeat (8) @(posedge CLOCK);
    #1;
  endtask

  initial begin
    RESET    = 1'b1;
    ENABLE   = 1'b0;
    PIX_DATA = '0;
    repeat (3) @(posedge CLOCK);
    #1;
    checkOutput("reset_state", sampleDut(), '0);
    RESET  = 1'b0;
    mon_en = 1'b1;
    repeat (3) @(posedge CLOCK);
    #1;
    $display("[TB] constant 0x2A5 source, ENABLE one cycle");
    applyStimulus(1, 0);
    $display("[TB] ramp source");
    applyStimulus(1, 1);
    $display("[TB] back-to-back random frames");
    applyStimulus(3, 2);
    $display("[TB] reset in row 1 word 2");
    applyMidFrameReset();
    $display("[TB] restart after reset");
    applyStimulus(1, 2);
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog cycle=%0d simulation did not complete, required completion", cyc_no);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
